// File: rtl/soc_evt_bus_tx.sv
// ---------------------------------------------------------------------------
// soc_evt_bus_tx
//
// SoC-side transmitter of the SoC-to-cluster event bus. NB_CHANNELS event
// sources are arbitrated (round-robin or fixed priority) into a ring of
// BUFFER_WIDTH slots. The ring is exported as a one-hot write token plus the
// full slot storage. The cluster returns a one-hot read pointer from another
// clock domain; it is synchronised here and only one-hot values are accepted.
//
// Ports:
//   clk_i          SoC clock
//   rst_ni         asynchronous active-low reset
//   evt_valid_i    per-channel event request
//   evt_data_i     per-channel event ID, channel k at [k*EVNT_WIDTH +: EVNT_WIDTH]
//   evt_ack_o      per-channel accept (combinational, at most one bit set)
//   evt_wt_o       one-hot write token, marks the next slot to be written
//   evt_da_o       registered slot storage, slot j at [j*EVNT_WIDTH +: EVNT_WIDTH]
//   evt_rp_i       cluster one-hot read pointer (asynchronous to clk_i)
//   full_o         ring full (one slot always left unused)
//   empty_o        ring empty as seen from the synchronised read pointer
//
// Optional feature (macro SOC_EVT_BUS_DROP_CNT_EN):
//   drop_cnt_clr_i clears the stall counter at the next edge
//   drop_cnt_o     saturating count of cycles with a request stalled by full
// ---------------------------------------------------------------------------
module soc_evt_bus_tx #(
    parameter int NB_CHANNELS  = 4,
    parameter int EVNT_WIDTH   = 8,
    parameter int BUFFER_WIDTH = 8,
    parameter int ARB_MODE     = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_CHANNELS-1:0]             evt_valid_i,
    input  logic [NB_CHANNELS*EVNT_WIDTH-1:0]  evt_data_i,
    output logic [NB_CHANNELS-1:0]             evt_ack_o,
    output logic [BUFFER_WIDTH-1:0]            evt_wt_o,
    output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] evt_da_o,
    input  logic [BUFFER_WIDTH-1:0]            evt_rp_i,
    output logic                               full_o,
    output logic                               empty_o
`ifdef SOC_EVT_BUS_DROP_CNT_EN
    ,
    input  logic                               drop_cnt_clr_i,
    output logic [15:0]                        drop_cnt_o
`endif
);

    localparam int IDX_W = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;

    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] rp_sync;
    logic                    rp_sync_onehot;
    logic [BUFFER_WIDTH-1:0] rp_q;
    logic [BUFFER_WIDTH-1:0] wt_rotl;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic                    grant_found;
    logic [IDX_W-1:0]        grant_idx;
    logic [EVNT_WIDTH-1:0]   grant_data;
    logic [IDX_W-1:0]        cand_idx;
    logic                    transfer;
    int                      cand;

    // Read-pointer synchroniser. Flops reset to all ones, which is not
    // one-hot, so the last-good pointer keeps its reset value until a real
    // pointer has crossed the chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= evt_rp_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign rp_sync        = sync_q[SYNC_STAGES-1];
    assign rp_sync_onehot = (rp_sync != '0) &&
                            ((rp_sync & (rp_sync - BUFFER_WIDTH'(1))) == '0);

    // Bits caught mid-transition can look like zero or two-hot; those
    // samples are ignored and the previous good pointer is kept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rp_q <= BUFFER_WIDTH'(1);
        end else if (rp_sync_onehot) begin
            rp_q <= rp_sync;
        end
    end

    // Full when the slot after the write token is the one being read:
    // writing it would overwrite data the receiver may still be sampling.
    assign wt_rotl = {evt_wt_o[BUFFER_WIDTH-2:0], evt_wt_o[BUFFER_WIDTH-1]};
    assign full_o  = |(wt_rotl & rp_q);
    assign empty_o = (evt_wt_o == rp_q);

    // Arbitration: scan channels starting at rr_ptr_q (round-robin) or at
    // channel 0 (fixed priority); the first requester found wins.
    always_comb begin
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        for (int i = 0; i < NB_CHANNELS; i++) begin
            if (ARB_MODE == 0) begin
                cand = int'(rr_ptr_q) + i;
            end else begin
                cand = i;
            end
            if (cand >= NB_CHANNELS) begin
                cand = cand - NB_CHANNELS;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && evt_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
                grant_data  = evt_data_i[cand*EVNT_WIDTH +: EVNT_WIDTH];
            end
        end
    end

    assign transfer = grant_found && !full_o;

    always_comb begin
        evt_ack_o = '0;
        if (transfer) begin
            evt_ack_o[grant_idx] = 1'b1;
        end
    end

    // Ring write: load the token slot and advance the token. Storage is
    // touched only on a transfer, so idle cycles cause no writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_wt_o <= BUFFER_WIDTH'(1);
            evt_da_o <= '0;
            rr_ptr_q <= '0;
        end else if (transfer) begin
            for (int j = 0; j < BUFFER_WIDTH; j++) begin
                if (evt_wt_o[j]) begin
                    evt_da_o[j*EVNT_WIDTH +: EVNT_WIDTH] <= grant_data;
                end
            end
            evt_wt_o <= wt_rotl;
            rr_ptr_q <= (grant_idx == IDX_W'(NB_CHANNELS-1)) ? '0
                                                             : grant_idx + IDX_W'(1);
        end
    end

`ifdef SOC_EVT_BUS_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Counts cycles in which some source wanted in but the ring was full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (drop_cnt_clr_i) begin
            drop_cnt_q <= '0;
        end else if (full_o && (|evt_valid_i) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
